// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiply is a 32-step LSB-first shift-add and divide is a 32-step MSB-first
// restoring divide. Both run on operand magnitudes, and the sign is applied
// when the result is captured. An operation takes 34 cycles from accept to done.
// Optional build macro: MULDIV_FAST_MUL_EN. When it is defined, the multiply
// ops finish in one cycle through a signed multiplier, going IDLE -> DONE.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;

    logic [2:0]        f3_r;
    logic [XLEN-1:0]   opa_r;
    logic [XLEN-1:0]   opb_r;
    logic [XLEN-1:0]   a_r;       // multiplier (shifts right) or dividend (shifts left)
    logic [2*XLEN-1:0] b_r;       // multiplicand (shifts left) or divisor in low half
    logic [2*XLEN-1:0] acc_r;     // product, or {remainder, quotient}
    logic [4:0]        cnt_r;
    logic              neg_r;     // negate product / quotient
    logic              rneg_r;    // negate remainder
    logic              busy_r;
    logic              done_r;
    logic [XLEN-1:0]   result_r;

    logic              is_div_s;
    logic              a_sgn_s;
    logic              b_sgn_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic [XLEN:0]     rem_sh_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] acc_step_s;
    logic [XLEN-1:0]   a_step_s;
    logic [2*XLEN-1:0] b_step_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   res_step_s;
    logic              fast_go_s;
    logic [XLEN-1:0]   fast_res_s;

    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] v);
        return ~v + 64'd1;
    endfunction

    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v, input logic sgn);
        if (sgn) begin
            return neg32(v);
        end else begin
            return v;
        end
    endfunction

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign is_div_s = f3_r[2];

    // Operand sign decode for the latched op; drives magnitudes taken in PREP.
    always_comb begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
        case (f3_r)
            F3_MULH, F3_DIV, F3_REM: begin
                a_sgn_s = opa_r[XLEN-1];
                b_sgn_s = opb_r[XLEN-1];
            end
            F3_MULHSU: begin
                a_sgn_s = opa_r[XLEN-1];
                b_sgn_s = 1'b0;
            end
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
            end
        endcase
        mag_a_s = mag32(opa_r, a_sgn_s);
        mag_b_s = mag32(opb_r, b_sgn_s);
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        rem_sh_s   = {acc_r[2*XLEN-1:XLEN], a_r[XLEN-1]};
        div_ge_s   = (rem_sh_s >= {1'b0, b_r[XLEN-1:0]});
        acc_step_s = acc_r;
        a_step_s   = a_r;
        b_step_s   = b_r;
        if (is_div_s) begin
            // Only the low 32 bits of the partial remainder survive a step.
            acc_step_s = {(div_ge_s ? (rem_sh_s[XLEN-1:0] - b_r[XLEN-1:0]) : rem_sh_s[XLEN-1:0]),
                          acc_r[XLEN-2:0], div_ge_s};
            a_step_s   = {a_r[XLEN-2:0], 1'b0};
        end else begin
            acc_step_s = acc_r + (a_r[0] ? b_r : 64'd0);
            a_step_s   = {1'b0, a_r[XLEN-1:1]};
            b_step_s   = {b_r[2*XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and result selection from the final step's accumulator.
    always_comb begin
        prod_s = neg_r  ? neg64(acc_step_s) : acc_step_s;
        quo_s  = neg_r  ? neg32(acc_step_s[XLEN-1:0]) : acc_step_s[XLEN-1:0];
        rem_s  = rneg_r ? neg32(acc_step_s[2*XLEN-1:XLEN]) : acc_step_s[2*XLEN-1:XLEN];
        case (f3_r)
            F3_MUL:                       res_step_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_step_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              res_step_s = quo_s;
            F3_REM, F3_REMU:              res_step_s = rem_s;
            default:                      res_step_s = 32'd0;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic               fast_a_sgn_s;
    logic               fast_b_sgn_s;
    logic signed [63:0] fast_a_s;
    logic signed [63:0] fast_b_s;
    logic signed [63:0] fast_prod_s;

    // Single-cycle signed multiply on sign- or zero-extended operands.
    always_comb begin
        fast_a_sgn_s = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
        fast_b_sgn_s = (funct3 == F3_MULH);
        fast_a_s     = {{32{fast_a_sgn_s & op_a[XLEN-1]}}, op_a};
        fast_b_s     = {{32{fast_b_sgn_s & op_b[XLEN-1]}}, op_b};
        fast_prod_s  = fast_a_s * fast_b_s;
        fast_go_s    = ~funct3[2];
        if (funct3 == F3_MUL) begin
            fast_res_s = fast_prod_s[XLEN-1:0];
        end else begin
            fast_res_s = fast_prod_s[2*XLEN-1:XLEN];
        end
    end
`else
    assign fast_go_s  = 1'b0;
    assign fast_res_s = 32'd0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (fast_go_s) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_PREP;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PREP: state_s = S_CALC;
            S_CALC: begin
                if (cnt_r == 5'd31) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath registers, handshake outputs and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_r     <= 3'd0;
            opa_r    <= 32'd0;
            opb_r    <= 32'd0;
            a_r      <= 32'd0;
            b_r      <= 64'd0;
            acc_r    <= 64'd0;
            cnt_r    <= 5'd0;
            neg_r    <= 1'b0;
            rneg_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        f3_r   <= funct3;
                        opa_r  <= op_a;
                        opb_r  <= op_b;
                        busy_r <= 1'b1;
                        if (fast_go_s) begin
                            result_r <= fast_res_s;
                            done_r   <= 1'b1;
                        end
                    end
                end
                S_PREP: begin
                    acc_r <= 64'd0;
                    cnt_r <= 5'd0;
                    if (is_div_s) begin
                        a_r    <= mag_a_s;
                        b_r    <= {32'd0, mag_b_s};
                        // Divide by zero keeps the all-ones quotient unsigned.
                        neg_r  <= (a_sgn_s ^ b_sgn_s) && (opb_r != 32'd0);
                        rneg_r <= a_sgn_s;
                    end else begin
                        a_r    <= mag_b_s;
                        b_r    <= {32'd0, mag_a_s};
                        neg_r  <= a_sgn_s ^ b_sgn_s;
                        rneg_r <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc_r <= acc_step_s;
                    a_r   <= a_step_s;
                    b_r   <= b_step_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        result_r <= res_step_s;
                        done_r   <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
